// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned PC_W             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // True when the byte PC addresses a word inside the instruction memory.
  function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned words);
    return 32'(pc[31:2]) < 32'(words);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the fetch unit (master) and its environment: imem, redirect, decode.
interface if_fetch_unit_if #(
  parameter int unsigned AW = 9
) ();

  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          fetch_fault;

  modport master (
    output imem_rd_en, imem_addr, out_valid, out_pc, out_instr, fetch_fault,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, out_valid, out_pc, out_instr, fetch_fault,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/if_fetch_unit_queue.sv
// Two-entry FIFO of fetched {pc, instr}; head is a register so outputs are registered.
module if_fetch_queue
  import if_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Flush wins over push/pop; push and pop in one cycle both apply.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues imem reads under a 2-credit limit,
// buffers returns in a 2-entry queue and hands {pc, instr} to decode.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned AW         = 9
) (
  input  logic              clock,
  input  logic              reset,
  if_fetch_unit_if.master   fetch_if
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tag_q, tag_d;
  logic         inflight_q, inflight_d;
  logic         fault_q, fault_d;

  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic         q_valid;
  logic         pop;
  logic         kill;
  logic         push;
  logic         credit_ok;
  logic         issue;
  logic [31:0]  issue_pc;

  assign q_valid   = (count != 2'd0);
  assign pop       = q_valid && fetch_if.out_ready;
  // The response landing in a redirect cycle belongs to a pre-redirect PC.
  assign kill      = fetch_if.redirect_valid;
  assign push      = inflight_q && !kill;
  assign push_data = '{pc: tag_q, instr: fetch_if.imem_rdata};
  assign issue_pc  = fetch_if.redirect_valid ? fetch_if.redirect_pc : pc_q;

  // A pop from a single-entry queue makes room for the word still in flight,
  // which sustains one fetch per cycle; a pop from a full queue frees credit next cycle.
  assign credit_ok = ((3'(count) + 3'(inflight_q)) < 3'd2) ||
                     ((count == 2'd1) && inflight_q && pop);

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    fault_d    = fault_q;
    issue      = 1'b0;
    if (fetch_if.redirect_valid) begin
      pc_d = fetch_if.redirect_pc + 32'd4;
      if ((fetch_if.redirect_pc[1:0] != 2'b00) ||
          !pc_in_range(fetch_if.redirect_pc, IMEM_WORDS)) begin
        fault_d = 1'b1;
      end else begin
        fault_d = 1'b0;
        issue   = 1'b1;
      end
    end else if (!fault_q && credit_ok) begin
      if (!pc_in_range(pc_q, IMEM_WORDS)) begin
        fault_d = 1'b1;
      end else begin
        issue = 1'b1;
        pc_d  = pc_q + 32'd4;
      end
    end
    if (issue) begin
      inflight_d = 1'b1;
      tag_d      = issue_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_q      <= 32'd0;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      fault_q    <= fault_d;
    end
  end

  if_fetch_queue u_queue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (fetch_if.redirect_valid),
    .data_i  (push_data),
    .head_o  (head),
    .count_o (count)
  );

  assign fetch_if.imem_rd_en  = issue && !reset;
  assign fetch_if.imem_addr   = issue_pc[AW+1:2];
  assign fetch_if.out_valid   = q_valid;
  assign fetch_if.out_pc      = head.pc;
  assign fetch_if.out_instr   = head.instr;
  assign fetch_if.fetch_fault = fault_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle table plus end-of-memory and async-reset sequences.
module tb_if_fetch_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  if_fetch_unit_if #(.AW(9)) bus ();

  if_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(512), .AW(9)) dut (
    .clock    (clock),
    .reset    (reset),
    .fetch_if (bus)
  );

  always #5 clock = ~clock;

  // Instruction memory model: word k holds k, one-cycle read latency.
  always_ff @(posedge clock) begin
    if (bus.imem_rd_en) bus.imem_rdata <= 32'(bus.imem_addr);
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic        erd;
    logic [8:0]  ea;
    logic        ef;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                              input logic erd, input logic [8:0] ea, input logic ef);
    vec_t v;
    v.ready = r; v.redir = rd; v.rpc = rpc; v.ev = ev; v.epc = epc; v.ei = ei;
    v.erd = erd; v.ea = ea; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the negedge, compare #1 later, then move to the next negedge.
  task automatic apply(input vec_t v, input string tag);
    bus.out_ready      = v.ready;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.rpc;
    #1;
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(v.ev));
    chk({tag, " rd_en"}, 32'(bus.imem_rd_en), 32'(v.erd));
    chk({tag, " fault"}, 32'(bus.fetch_fault), 32'(v.ef));
    if (v.ev) begin
      chk({tag, " out_pc"}, bus.out_pc, v.epc);
      chk({tag, " out_instr"}, bus.out_instr, v.ei);
    end
    if (v.erd) chk({tag, " addr"}, 32'(bus.imem_addr), 32'(v.ea));
    @(negedge clock);
  endtask

  initial begin
    int          issues;
    int          got_n;
    logic [31:0] got_pc [4];
    logic [31:0] got_in [4];

    // Streaming from reset, stall, release.
    vecs[0]  = mk(1, 0, 0,   0, 0,  0, 1, 0, 0);
    vecs[1]  = mk(1, 0, 0,   0, 0,  0, 1, 1, 0);
    vecs[2]  = mk(1, 0, 0,   1, 0,  0, 1, 2, 0);
    vecs[3]  = mk(1, 0, 0,   1, 4,  1, 1, 3, 0);
    vecs[4]  = mk(1, 0, 0,   1, 8,  2, 1, 4, 0);
    vecs[5]  = mk(1, 0, 0,   1, 12, 3, 1, 5, 0);
    for (int i = 6; i <= 10; i++) vecs[i] = mk(0, 0, 0, 1, 16, 4, 0, 0, 0);
    vecs[11] = mk(1, 0, 0,   1, 16, 4, 0, 0, 0);
    vecs[12] = mk(1, 0, 0,   1, 20, 5, 1, 6, 0);
    vecs[13] = mk(1, 0, 0,   0, 0,  0, 1, 7, 0);
    vecs[14] = mk(1, 0, 0,   1, 24, 6, 1, 8, 0);
    vecs[15] = mk(1, 0, 0,   1, 28, 7, 1, 9, 0);
    // Redirect with a full queue, then with a word in flight (stale return must vanish).
    vecs[16] = mk(0, 0, 0,          1, 32,       8,  0, 0,  0);
    vecs[17] = mk(0, 1, 32'h40,     1, 32,       8,  1, 16, 0);
    vecs[18] = mk(1, 0, 0,          0, 0,        0,  1, 17, 0);
    vecs[19] = mk(1, 0, 0,          1, 32'h40,   16, 1, 18, 0);
    vecs[20] = mk(1, 0, 0,          1, 32'h44,   17, 1, 19, 0);
    vecs[21] = mk(1, 1, 32'h100,    1, 32'h48,   18, 1, 64, 0);
    vecs[22] = mk(1, 0, 0,          0, 0,        0,  1, 65, 0);
    vecs[23] = mk(1, 0, 0,          1, 32'h100,  64, 1, 66, 0);
    // Misaligned redirect faults; aligned redirect recovers.
    vecs[24] = mk(1, 1, 32'h42,     1, 32'h104,  65, 0, 0,  0);
    vecs[25] = mk(1, 0, 0,          0, 0,        0,  0, 0,  1);
    vecs[26] = mk(1, 0, 0,          0, 0,        0,  0, 0,  1);
    vecs[27] = mk(1, 1, 32'h80,     0, 0,        0,  1, 32, 1);
    vecs[28] = mk(1, 0, 0,          0, 0,        0,  1, 33, 0);
    vecs[29] = mk(1, 0, 0,          1, 32'h80,   32, 1, 34, 0);

    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    #2;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset rd_en", 32'(bus.imem_rd_en), 32'd0);
    chk("reset out_pc", bus.out_pc, 32'd0);
    chk("reset out_instr", bus.out_instr, 32'd0);
    chk("reset fault", 32'(bus.fetch_fault), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 30; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Walk off the end of memory: words 510 and 511 delivered, then fault, no more issues.
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h7F8;
    #1;
    chk("eom redirect rd_en", 32'(bus.imem_rd_en), 32'd1);
    chk("eom redirect addr", 32'(bus.imem_addr), 32'd510);
    @(negedge clock);
    bus.redirect_valid = 1'b0;
    issues = 0;
    got_n  = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.imem_rd_en) begin
        issues++;
        chk("eom issue addr", 32'(bus.imem_addr), 32'd511);
      end
      if (bus.out_valid && got_n < 4) begin
        got_pc[got_n] = bus.out_pc;
        got_in[got_n] = bus.out_instr;
        got_n++;
      end
      @(negedge clock);
    end
    chk("eom issue count", 32'(issues), 32'd1);
    chk("eom delivered count", 32'(got_n), 32'd2);
    if (got_n >= 2) begin
      chk("eom pc0", got_pc[0], 32'h7F8);
      chk("eom instr0", got_in[0], 32'd510);
      chk("eom pc1", got_pc[1], 32'h7FC);
      chk("eom instr1", got_in[1], 32'd511);
    end
    #1;
    chk("eom fault", 32'(bus.fetch_fault), 32'd1);
    chk("eom out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);

    // Restart mid-memory, then assert reset asynchronously while streaming.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    @(negedge clock);
    bus.redirect_valid = 1'b0;
    @(negedge clock);
    #1;
    chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre-reset out_pc", bus.out_pc, 32'h10);
    chk("pre-reset fault", 32'(bus.fetch_fault), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("async reset out_pc", bus.out_pc, 32'd0);
    chk("async reset out_instr", bus.out_instr, 32'd0);
    chk("async reset rd_en", 32'(bus.imem_rd_en), 32'd0);
    chk("async reset fault", 32'(bus.fetch_fault), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) apply(vecs[i], $sformatf("restart%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
